serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to add; sampled only in IDLE.
REQ-005 a  input  WIDTH  addend A; captured on the accepted start edge.
REQ-006 b  input  WIDTH  addend B; captured on the accepted start edge.
REQ-007 cin  input  1  carry-in; captured on the accepted start edge.
REQ-008 busy  output  1  high while in SHIFT or DONE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 sum  output  WIDTH  result A+B+cin mod 2^WIDTH; registered.
REQ-011 cout  output  1  carry-out of the WIDTH-bit addition; registered.

Function
REQ-012 The FSM shall have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 at a rising edge, the block shall load a and b into shift registers, load carry with cin, clear the bit counter, and enter SHIFT.
REQ-014 In IDLE with start=0, the block shall remain in IDLE with no register change.
REQ-015 Each SHIFT edge shall feed the LSBs of the A and B shift registers plus carry through one full-adder cell, shift the sum bit into a result register from the MSB side, update carry with the cell carry, shift A and B right by one, and increment the counter.
REQ-016 The block shall stay in SHIFT for exactly WIDTH edges, processing bit 0 first and bit WIDTH-1 last.
REQ-017 On the WIDTH-th SHIFT edge, the block shall copy the completed result to sum and the final carry to cout, and enter DONE.
REQ-018 DONE shall last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency: with start accepted at edge k, done shall be high in the cycle following edge k+WIDTH, and the next start shall be accepted no earlier than edge k+WIDTH+2.
REQ-020 sum and cout shall change only at the REQ-017 edge and hold their values until the next completion or reset; partial results shall never appear on sum.
REQ-021 start asserted in SHIFT or DONE shall be ignored, with no queuing, and a, b and cin changes after capture shall not affect the result.
REQ-022 Arithmetic shall be unsigned with no overflow flag; wrap-around is reported solely via cout.
REQ-023 The counter shall be ceil(log2(WIDTH+1)) bits wide and shall not wrap within one operation.

Reset
REQ-024 With rst_n=0, regardless of clk, the block shall force: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, shift registers=0.
REQ-025 Reset asserted mid-SHIFT shall abort the operation with no done pulse, and sum/cout shall read 0.
REQ-026 After rst_n deasserts, the first start shall be accepted at the first rising edge where start=1.

Structure
REQ-027 A shared package serial_adder_pkg shall hold the state enumeration (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-028 The one-bit add shall be a sub-module full_adder (inputs a, b, cin; outputs s, co), instantiated once in serial_adder.
REQ-029 The block shall contain no combinational path from inputs to outputs; busy and done shall be decoded from registered state only.

Verification (WIDTH=8)
REQ-030 a=0x05, b=0x03, cin=0, start pulse -> done after 8 cycles; sum=0x08, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 start held high continuously with a=0x10, b=0x20 -> done pulses every 10 cycles, each pulse one cycle wide; sum=0x30 throughout.
REQ-033 During SHIFT, pulse start with a=0xAA, b=0x55 -> ignored; result reflects the original operands; exactly one done pulse.
REQ-034 rst_n low at SHIFT cycle 4 of 0x7F+0x01 -> no done pulse; sum=0x00, cout=0, busy=0; the next op 0x7F+0x01 -> sum=0x80, cout=0.
REQ-035 Randomised 1000 operations compared against a+b+cin reference -> zero mismatches; sum is stable between done pulses.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and default operand width for the bit-serial adder.
package serial_adder_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam int WIDTH_DEFAULT = 8;
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: one-bit full-adder cell used by the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per clock, registered sum/cout.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co, last;
    full_adder u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );
    assign last = cnt_q == CW'(WIDTH - 1);
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SHIFT;
                a_d     = a;
                b_d     = b;
                carry_d = cin;
                cnt_d   = '0;
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                // sum/cout are only exposed once the last bit has been shifted in
                if (last) begin
                    state_d = DONE;
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against an a+b+cin reference.
module tb_serial_adder;
    localparam int W = 8;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    int           checks = 0, failures = 0;
    logic [W-1:0] exp_sum = '0;
    logic         exp_cout = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle j=1 is the cycle after the accepting edge; done belongs to cycle W+1.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input bit poke);
        logic [W:0] r;
        r = (W+1)'(av) + (W+1)'(bv) + (W+1)'(cv);
        @(negedge clk);
        start = 1'b1; a = av; b = bv; cin = cv;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int j = 1; j <= W + 2; j++) begin
            if (j > 1) @(negedge clk);
            chk("busy", busy, 32'(j <= W + 1));
            chk("done", done, 32'(j == W + 1));
            chk("sum", sum, 32'(j <= W ? exp_sum : r[W-1:0]));
            chk("cout", cout, 32'(j <= W ? exp_cout : r[W]));
            if (poke && j == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
            end
            if (poke && j == 4) start = 1'b0;
        end
        exp_sum  = r[W-1:0];
        exp_cout = r[W];
    endtask

    initial begin
        int last, pulses;
        logic prev_done;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;
        run_op(8'h05, 8'h03, 1'b0, 1'b0);
        chk("ex1_sum", sum, 8'h08);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        chk("ex2_sum", sum, 8'h00);
        chk("ex2_cout", cout, 1);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        chk("ex3_sum", sum, 8'hFF);
        chk("ex3_cout", cout, 1);
        run_op(8'h12, 8'h34, 1'b0, 1'b1);
        chk("poke_sum", sum, 8'h46);
        // start held high: back-to-back ops every W+2 cycles
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        last = 0; pulses = 0; prev_done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk("held_width", 32'(done && prev_done), 0);
            if (done) begin
                pulses++;
                chk("held_gap", last == 0 ? c : c - last, last == 0 ? W + 1 : W + 2);
                last = c;
            end
            if (pulses > 0) chk("held_sum", sum, 8'h30);
            prev_done = done;
        end
        chk("held_pulses", pulses, 4);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        chk("held_idle", busy, 0);
        exp_sum = 8'h30; exp_cout = 1'b0;
        // reset in the middle of SHIFT aborts with no done pulse
        start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_sum = '0; exp_cout = 1'b0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            chk("abort_nodone", done, 0);
            chk("abort_hold", sum, 0);
        end
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        chk("after_abort_sum", sum, 8'h80);
        chk("after_abort_cout", cout, 0);
        for (int n = 0; n < 1000; n++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
